// File: rtl/pll_mode_sequencer.sv
// pll_mode_sequencer: turns a requested video mode index into the ROM selector and reset pulse for the
// reconfigurable PLL wrapper. It filters request glitches, waits for qualified lock with timeout/retry,
// and holds the video domain in reset until lock is qualified for the applied mode.
// Ports: clock/reset_n (async active-low); mode_req, pll_locked (async, 2-flop synchronised);
//   pll_data/mode_active (applied mode), pll_reset (active-high PLL reset), video_reset_n,
//   busy (not RUN/FAIL), error (FAIL).
// Optional feature: define PLL_LOCKLOSS_RECOVERY_EN to re-pulse pll_reset on lock loss in RUN;
//   by default lock loss in RUN only returns to WAIT_LOCK and leaves recovery to the wrapper.
`timescale 1ns/1ps
module pll_mode_sequencer #(
  parameter logic [7:0] DEFAULT_MODE  = 8'd0,
  parameter int         STABLE_CYCLES = 16,
  parameter int         RESET_CYCLES  = 32,
  parameter int         LOCK_STABLE   = 256,
  parameter int         LOCK_TIMEOUT  = 2**20,
  parameter int         MAX_RETRIES   = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] mode_req,
  input  logic       pll_locked,
  output logic [7:0] pll_data,
  output logic       pll_reset,
  output logic       video_reset_n,
  output logic [7:0] mode_active,
  output logic       busy,
  output logic       error
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int LW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int NW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [SW-1:0] STABLE_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] PULSE_LAST   = RW'(RESET_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST    = LW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [NW-1:0] RETRY_MAX    = NW'(MAX_RETRIES);

  typedef enum logic [2:0] {SETTLE, APPLY, WAIT_LOCK, RUN, FAIL} state_t;

  state_t state, state_next;

  logic [7:0]    req_meta, req_sync, req_prev;
  logic          lock_meta, lock_sync;
  logic [7:0]    mode_q;
  logic          pll_reset_q;
  logic [SW-1:0] stable_cnt;
  logic [RW-1:0] pulse_cnt;
  logic [LW-1:0] lock_cnt;
  logic [TW-1:0] timeout_cnt;
  logic [NW-1:0] retries;
  logic          mode_change;

  // Synchronisers; req_prev is one more stage so SETTLE can compare consecutive samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_meta  <= DEFAULT_MODE;
      req_sync  <= DEFAULT_MODE;
      req_prev  <= DEFAULT_MODE;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      req_meta  <= mode_req;
      req_sync  <= req_meta;
      req_prev  <= req_sync;
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
    end
  end

  // A request equal to the applied mode never counts as a change.
  assign mode_change = (req_sync != mode_q);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= SETTLE;
    else          state <= state_next;
  end

  // Next-state logic; mode change always takes priority over lock/timeout events.
  always_comb begin
    state_next = state;
    case (state)
      SETTLE:    if (req_sync == req_prev && stable_cnt == STABLE_LAST) state_next = APPLY;
      APPLY:     if (pulse_cnt == PULSE_LAST) state_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (mode_change)                             state_next = SETTLE;
        else if (lock_sync && lock_cnt == LOCK_LAST) state_next = RUN;
        else if (timeout_cnt == TIMEOUT_LAST)        state_next = (retries < RETRY_MAX) ? APPLY : FAIL;
      end
      RUN: begin
        if (mode_change) state_next = SETTLE;
`ifdef PLL_LOCKLOSS_RECOVERY_EN
        else if (!lock_sync) state_next = APPLY;
`else
        else if (!lock_sync) state_next = WAIT_LOCK;
`endif
      end
      FAIL:      if (mode_change) state_next = SETTLE;
      default:   state_next = SETTLE;
    endcase
  end

  // Per-state counters restart on every state change; all saturate at their last value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable_cnt  <= '0;
      pulse_cnt   <= '0;
      lock_cnt    <= '0;
      timeout_cnt <= '0;
    end else if (state_next != state) begin
      stable_cnt  <= '0;
      pulse_cnt   <= '0;
      lock_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        SETTLE: begin
          if (req_sync != req_prev)        stable_cnt <= '0;
          else if (stable_cnt != STABLE_LAST) stable_cnt <= stable_cnt + 1'b1;
        end
        APPLY: if (pulse_cnt != PULSE_LAST) pulse_cnt <= pulse_cnt + 1'b1;
        WAIT_LOCK: begin
          if (!lock_sync)                lock_cnt <= '0;
          else if (lock_cnt != LOCK_LAST) lock_cnt <= lock_cnt + 1'b1;
          if (timeout_cnt != TIMEOUT_LAST) timeout_cnt <= timeout_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Applied mode, PLL reset and retry bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= DEFAULT_MODE;
      pll_reset_q <= 1'b1;
      retries     <= '0;
    end else begin
      // Only a fresh request from SETTLE changes the selector; retries re-apply the same mode.
      if (state == SETTLE && state_next == APPLY) mode_q <= req_sync;
      // SETTLE keeps whatever level pll_reset already has.
      if (state_next == APPLY)       pll_reset_q <= 1'b1;
      else if (state_next != SETTLE) pll_reset_q <= 1'b0;
      if (state == RUN || state_next == SETTLE)
        retries <= '0;
      else if (state == WAIT_LOCK && state_next == APPLY && retries != RETRY_MAX)
        retries <= retries + 1'b1;
    end
  end

  // Outputs
  always_comb begin
    pll_data      = mode_q;
    mode_active   = mode_q;
    pll_reset     = pll_reset_q;
    video_reset_n = (state == RUN);
    busy          = !(state == RUN || state == FAIL);
    error         = (state == FAIL);
  end

endmodule

// File: tb/tb_pll_mode_sequencer.sv
`timescale 1ns/1ps
module tb_pll_mode_sequencer;
  localparam int STABLE_CYCLES = 4;
  localparam int RESET_CYCLES  = 4;
  localparam int LOCK_STABLE   = 8;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int MAX_RETRIES   = 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] mode_req;
  logic       pll_locked;
  logic [7:0] pll_data;
  logic       pll_reset;
  logic       video_reset_n;
  logic [7:0] mode_active;
  logic       busy;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected successive pll_data values, pushed with the stimulus that causes them.
  logic [7:0] exp_q[$];
  logic [7:0] last_data = 8'h00;

  pll_mode_sequencer #(
    .DEFAULT_MODE (8'd0),
    .STABLE_CYCLES(STABLE_CYCLES),
    .RESET_CYCLES (RESET_CYCLES),
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .mode_req     (mode_req),
    .pll_locked   (pll_locked),
    .pll_data     (pll_data),
    .pll_reset    (pll_reset),
    .video_reset_n(video_reset_n),
    .mode_active  (mode_active),
    .busy         (busy),
    .error        (error)
  );

  always #5 clock = ~clock;

  // Advance to the next falling edge and compare any pll_data change against the scoreboard.
  task automatic tick();
    logic [7:0] e;
    @(negedge clock);
    if (pll_data !== last_data) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_change: pll_data=%h, no change expected", pll_data);
      end else begin
        e = exp_q.pop_front();
        if (pll_data !== e) begin
          n_fail++;
          $display("FAIL sb_pll_data: got %h, expected %h", pll_data, e);
        end
      end
      last_data = pll_data;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_data(input logic [7:0] v, output int n);
    n = 0;
    while (pll_data !== v && n < 200) begin tick(); n++; end
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (pll_reset === 1'b1 && n < 200) begin tick(); n++; end
  endtask

  task automatic wait_video(input logic v, output int n);
    n = 0;
    while (video_reset_n !== v && n < 300) begin tick(); n++; end
  endtask

  task automatic test_reset();
    reset_n = 1'b1; mode_req = 8'h03; pll_locked = 1'b0;
    #1 reset_n = 1'b0;
    ticks(3);
    n_checks++; if (pll_data !== 8'h00) begin n_fail++; $display("FAIL reset_pll_data: got %h want 00", pll_data); end
    n_checks++; if (mode_active !== 8'h00) begin n_fail++; $display("FAIL reset_mode_active: got %h want 00", mode_active); end
    n_checks++; if (pll_reset !== 1'b1) begin n_fail++; $display("FAIL reset_pll_reset: got %b want 1", pll_reset); end
    n_checks++; if (video_reset_n !== 1'b0) begin n_fail++; $display("FAIL reset_video: got %b want 0", video_reset_n); end
    n_checks++; if (busy !== 1'b1 || error !== 1'b0) begin n_fail++; $display("FAIL reset_busy_error: got %b/%b want 1/0", busy, error); end
  endtask

  task automatic test_bringup();
    int n;
    exp_q.push_back(8'h03);
    reset_n = 1'b1;
    wait_data(8'h03, n);
    n_checks++; if (pll_data !== 8'h03 || mode_active !== 8'h03) begin n_fail++; $display("FAIL bringup_apply: pll_data=%h mode_active=%h want 03", pll_data, mode_active); end
    count_high(n);
    n_checks++; if (n != RESET_CYCLES) begin n_fail++; $display("FAIL bringup_pulse: %0d cycles want %0d", n, RESET_CYCLES); end
    ticks(10);
    pll_locked = 1'b1;
    wait_video(1'b1, n);
    n_checks++; if (n != LOCK_STABLE + 2) begin n_fail++; $display("FAIL bringup_lock_delay: %0d cycles want %0d", n, LOCK_STABLE + 2); end
    n_checks++; if (busy !== 1'b0 || error !== 1'b0 || pll_reset !== 1'b0) begin n_fail++; $display("FAIL bringup_run: busy=%b error=%b pll_reset=%b want 0/0/0", busy, error, pll_reset); end
  endtask

  task automatic test_glitch();
    int n;
    bit seen05 = 0;
    exp_q.push_back(8'h06);
    for (int r = 0; r < 3; r++) begin
      mode_req = 8'h05;
      repeat (2) begin tick(); if (pll_data === 8'h05) seen05 = 1; end
      mode_req = 8'h06;
      if (r < 2) repeat (2) begin tick(); if (pll_data === 8'h05) seen05 = 1; end
    end
    n = 0;
    while (pll_data !== 8'h06 && n < 50) begin tick(); if (pll_data === 8'h05) seen05 = 1; n++; end
    n_checks++; if (seen05) begin n_fail++; $display("FAIL glitch_no05: pll_data took 05, must not"); end
    n_checks++; if (pll_data !== 8'h06 || n < STABLE_CYCLES + 2 || n > STABLE_CYCLES + 4) begin
      n_fail++; $display("FAIL glitch_settle: pll_data=%h after %0d cycles want 06 after %0d..%0d", pll_data, n, STABLE_CYCLES + 2, STABLE_CYCLES + 4);
    end
    n_checks++; if (pll_reset !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL glitch_apply: pll_reset=%b busy=%b want 1/1", pll_reset, busy); end
    wait_video(1'b1, n);
    n_checks++; if (video_reset_n !== 1'b1 || n > RESET_CYCLES + LOCK_STABLE + 2) begin n_fail++; $display("FAIL glitch_relock: video=%b after %0d cycles", video_reset_n, n); end
  endtask

  task automatic test_timeout_fail();
    int n, lo;
    exp_q.push_back(8'h08);
    mode_req = 8'h08; pll_locked = 1'b0;
    wait_data(8'h08, n);
    n_checks++; if (pll_data !== 8'h08) begin n_fail++; $display("FAIL fail_apply: pll_data=%h want 08", pll_data); end
    for (int a = 0; a <= MAX_RETRIES; a++) begin
      count_high(n);
      n_checks++; if (n != RESET_CYCLES) begin n_fail++; $display("FAIL fail_pulse%0d: %0d cycles want %0d", a, n, RESET_CYCLES); end
      lo = 0;
      while (pll_reset !== 1'b1 && error !== 1'b1 && lo < 300) begin tick(); lo++; end
      n_checks++; if (lo != LOCK_TIMEOUT) begin n_fail++; $display("FAIL fail_gap%0d: %0d cycles want %0d", a, lo, LOCK_TIMEOUT); end
    end
    n_checks++; if (error !== 1'b1 || busy !== 1'b0 || pll_reset !== 1'b0 || video_reset_n !== 1'b0) begin
      n_fail++; $display("FAIL fail_state: error=%b busy=%b pll_reset=%b video=%b want 1/0/0/0", error, busy, pll_reset, video_reset_n);
    end
    ticks(20);
    n_checks++; if (error !== 1'b1 || pll_reset !== 1'b0) begin n_fail++; $display("FAIL fail_sticky: error=%b pll_reset=%b want 1/0", error, pll_reset); end
    exp_q.push_back(8'h07);
    mode_req = 8'h07;
    wait_data(8'h07, n);
    n_checks++; if (pll_data !== 8'h07 || error !== 1'b0 || busy !== 1'b1 || pll_reset !== 1'b1) begin
      n_fail++; $display("FAIL fail_exit: pll_data=%h error=%b busy=%b pll_reset=%b want 07/0/1/1", pll_data, error, busy, pll_reset);
    end
    count_high(n);
    n_checks++; if (n != RESET_CYCLES) begin n_fail++; $display("FAIL fail_exit_pulse: %0d cycles want %0d", n, RESET_CYCLES); end
  endtask

  task automatic test_lock_chatter();
    int n;
    pll_locked = 1'b1; ticks(7);
    pll_locked = 1'b0; ticks(1);
    pll_locked = 1'b1;
    wait_video(1'b1, n);
    n_checks++; if (n != LOCK_STABLE + 2) begin n_fail++; $display("FAIL chatter_lock: video rose after %0d cycles want %0d", n, LOCK_STABLE + 2); end
  endtask

  task automatic test_lock_drop();
    int n;
    bit pulsed = 0;
    pll_locked = 1'b0;
    wait_video(1'b0, n);
    n_checks++; if (n != 3) begin n_fail++; $display("FAIL drop_video: fell after %0d cycles want 3", n); end
`ifdef PLL_LOCKLOSS_RECOVERY_EN
    n_checks++; if (pll_reset !== 1'b1) begin n_fail++; $display("FAIL drop_pulse_start: pll_reset=%b want 1", pll_reset); end
    count_high(n);
    n_checks++; if (n != RESET_CYCLES) begin n_fail++; $display("FAIL drop_pulse: %0d cycles want %0d", n, RESET_CYCLES); end
`else
    repeat (4) begin if (pll_reset !== 1'b0) pulsed = 1; tick(); end
    n_checks++; if (pulsed || busy !== 1'b1) begin n_fail++; $display("FAIL drop_no_pulse: pulsed=%b busy=%b want 0/1", pulsed, busy); end
`endif
    pll_locked = 1'b1;
    wait_video(1'b1, n);
    n_checks++; if (n != LOCK_STABLE + 2 || pll_data !== 8'h07) begin
      n_fail++; $display("FAIL drop_relock: %0d cycles pll_data=%h want %0d/07", n, pll_data, LOCK_STABLE + 2);
    end
  endtask

  task automatic test_async_reset();
    int n;
    exp_q.push_back(8'h09);
    mode_req = 8'h09; pll_locked = 1'b0;
    wait_data(8'h09, n);
    count_high(n);
    ticks(5);
    n_checks++; if (pll_reset !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL areset_waitlock: pll_reset=%b busy=%b want 0/1", pll_reset, busy); end
    exp_q.push_back(8'h00);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (pll_data !== 8'h00 || mode_active !== 8'h00 || pll_reset !== 1'b1 || video_reset_n !== 1'b0 || busy !== 1'b1 || error !== 1'b0) begin
      n_fail++; $display("FAIL areset_values: data=%h active=%h rst=%b vid=%b busy=%b err=%b want 00/00/1/0/1/0",
                         pll_data, mode_active, pll_reset, video_reset_n, busy, error);
    end
    ticks(3);
    pll_locked = 1'b1;
    exp_q.push_back(8'h09);
    reset_n = 1'b1;
    wait_data(8'h09, n);
    n_checks++; if (pll_data !== 8'h09) begin n_fail++; $display("FAIL areset_reapply: pll_data=%h want 09", pll_data); end
    count_high(n);
    n_checks++; if (n != RESET_CYCLES) begin n_fail++; $display("FAIL areset_pulse: %0d cycles want %0d", n, RESET_CYCLES); end
    wait_video(1'b1, n);
    n_checks++; if (n != LOCK_STABLE || busy !== 1'b0) begin n_fail++; $display("FAIL areset_run: %0d cycles busy=%b want %0d/0", n, busy, LOCK_STABLE); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch();
    test_timeout_fail();
    test_lock_chatter();
    test_lock_drop();
    test_async_reset();
    ticks(2);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover: %0d expected values never seen, want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
